// File: rtl/approx_dot_acc.sv
// Streaming accumulator summing LEN unsigned 16-bit products into an ACC_W-bit result with sticky overflow.
// Define APPROX_DOT_ACC_SAT_EN to clamp on overflow instead of wrapping.
module approx_dot_acc #(
   parameter int LEN   = 8,
   parameter int ACC_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      prod,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic             out_ovf
);

   localparam int CNT_W = $clog2(LEN + 1);

   typedef enum logic {ACC, HOLD} state_t;

   state_t             state;
   logic [ACC_W-1:0]   acc;
   logic [CNT_W-1:0]   cnt;
   logic               ovf;

   logic [ACC_W:0]     sum;
   logic [ACC_W-1:0]   acc_nxt;
   logic               ovf_nxt;
   logic               take;
   logic               last;

   always_comb begin
      take    = in_valid && in_ready;
      last    = (cnt == CNT_W'(LEN - 1));
      sum     = {1'b0, acc} + (ACC_W + 1)'(prod);
      ovf_nxt = ovf | sum[ACC_W];
`ifdef APPROX_DOT_ACC_SAT_EN
      // Once clamped, stay at all-ones for the rest of this dot product.
      acc_nxt = ovf_nxt ? '1 : sum[ACC_W-1:0];
`else
      acc_nxt = sum[ACC_W-1:0];
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ACC;
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         out_sum   <= '0;
         out_ovf   <= 1'b0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state)
            ACC: begin
               if (take) begin
                  acc <= acc_nxt;
                  cnt <= cnt + CNT_W'(1);
                  ovf <= ovf_nxt;
                  if (last) begin
                     out_sum   <= acc_nxt;
                     out_ovf   <= ovf_nxt;
                     state     <= HOLD;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  acc       <= '0;
                  cnt       <= '0;
                  ovf       <= 1'b0;
                  state     <= ACC;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
               end
            end
            default: state <= ACC;
         endcase
      end
   end

endmodule

// File: tb/tb_approx_dot_acc.sv
// Bench for approx_dot_acc: three instances (LEN=4/ACC_W=24, LEN=2/ACC_W=16, LEN=1/ACC_W=24),
// directed sequences, a vector table and randomized dot products against an arithmetic model.
module tb_approx_dot_acc;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        iv  [3];
   logic        ord [3];
   logic        ir  [3];
   logic        ov  [3];
   logic        of  [3];
   logic [15:0] pr  [3];
   logic [31:0] os  [3];
   logic [23:0] s0, s2;
   logic [15:0] s1;

   int checks   = 0;
   int failures = 0;

   localparam int WID [3] = '{24, 16, 24};
   localparam int LNS [3] = '{4, 2, 1};

   always #5 clk = ~clk;

   approx_dot_acc #(.LEN(4), .ACC_W(24)) d0 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .prod(pr[0]),
      .out_valid(ov[0]), .out_ready(ord[0]), .out_sum(s0), .out_ovf(of[0]));
   approx_dot_acc #(.LEN(2), .ACC_W(16)) d1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .prod(pr[1]),
      .out_valid(ov[1]), .out_ready(ord[1]), .out_sum(s1), .out_ovf(of[1]));
   approx_dot_acc #(.LEN(1), .ACC_W(24)) d2 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .prod(pr[2]),
      .out_valid(ov[2]), .out_ready(ord[2]), .out_sum(s2), .out_ovf(of[2]));

   assign os[0] = 32'(s0);
   assign os[1] = 32'(s1);
   assign os[2] = 32'(s2);

   typedef struct {
      int          k;
      int          n;
      logic [15:0] b [4];
      logic [31:0] s;
      logic        o;
   } vec_t;

   vec_t tv [7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: the exact integer total decides overflow; the result wraps or clamps.
   task automatic model(int w, longint total, output logic [31:0] s, output logic o);
      longint lim;
      lim = longint'(1) << w;
      o   = (total >= lim);
`ifdef APPROX_DOT_ACC_SAT_EN
      s   = o ? 32'(lim - 1) : 32'(total);
`else
      s   = 32'(total % lim);
`endif
   endtask

   task automatic beat(int k, logic [15:0] v, int gap);
      int n;
      for (int g = 0; g < gap; g++) begin
         iv[k] = 1'b0;
         pr[k] = 16'($urandom);
         tick();
      end
      iv[k] = 1'b1;
      pr[k] = v;
      n = 0;
      while (!ir[k] && n < 100) begin
         tick();
         n++;
      end
      if (!ir[k]) begin
         checks++;
         failures++;
         $display("FAIL beat_timeout%0d: got in_ready=0 expected 1", k);
      end
      tick();
      iv[k] = 1'b0;
      pr[k] = 16'($urandom);
   endtask

   task automatic expect_result(int k, logic [31:0] es, logic eo, int hold, string nm);
      int n;
      n = 0;
      while (!ov[k] && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (!ov[k]) begin
         failures++;
         $display("FAIL %s_timeout: got out_valid=0 expected 1", nm);
         return;
      end
      for (int h = 0; h <= hold; h++) begin
         check($sformatf("%s_sum", nm), os[k], es);
         check($sformatf("%s_ovf", nm), 32'(of[k]), 32'(eo));
         check($sformatf("%s_inrdy", nm), 32'(ir[k]), 32'd0);
         if (h < hold) tick();
      end
      ord[k] = 1'b1;
      tick();
      ord[k] = 1'b0;
      check($sformatf("%s_valid_clr", nm), 32'(ov[k]), 32'd0);
      check($sformatf("%s_inrdy_set", nm), 32'(ir[k]), 32'd1);
   endtask

   task automatic set_vec(int i, int k, int n, logic [15:0] b0, logic [15:0] b1,
                          logic [15:0] b2, logic [15:0] b3, logic [31:0] s, logic o);
      tv[i].k    = k;
      tv[i].n    = n;
      tv[i].b[0] = b0;
      tv[i].b[1] = b1;
      tv[i].b[2] = b2;
      tv[i].b[3] = b3;
      tv[i].s    = s;
      tv[i].o    = o;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] es;
      logic        eo;
      longint      total;

      set_vec(0, 0, 4, 16'd1, 16'd2, 16'd3, 16'd4, 32'd10, 1'b0);
      set_vec(1, 0, 4, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 32'h3FFFC, 1'b0);
      set_vec(2, 1, 2, 16'h7FFF, 16'h8000, 16'd0, 16'd0, 32'hFFFF, 1'b0);
`ifdef APPROX_DOT_ACC_SAT_EN
      set_vec(3, 1, 2, 16'h8000, 16'h8000, 16'd0, 16'd0, 32'hFFFF, 1'b1);
      set_vec(6, 1, 2, 16'hFFFF, 16'hFFFF, 16'd0, 16'd0, 32'hFFFF, 1'b1);
`else
      set_vec(3, 1, 2, 16'h8000, 16'h8000, 16'd0, 16'd0, 32'h0, 1'b1);
      set_vec(6, 1, 2, 16'hFFFF, 16'hFFFF, 16'd0, 16'd0, 32'hFFFE, 1'b1);
`endif
      set_vec(4, 2, 1, 16'hFFFF, 16'd0, 16'd0, 16'd0, 32'hFFFF, 1'b0);
      set_vec(5, 2, 1, 16'd0, 16'd0, 16'd0, 16'd0, 32'd0, 1'b0);

      for (int k = 0; k < 3; k++) begin
         iv[k]  = 1'b0;
         ord[k] = 1'b0;
         pr[k]  = '0;
      end

      // Reset state
      repeat (3) tick();
      for (int k = 0; k < 3; k++) begin
         check($sformatf("rst_valid%0d", k), 32'(ov[k]), 32'd0);
         check($sformatf("rst_sum%0d", k), os[k], 32'd0);
         check($sformatf("rst_ovf%0d", k), 32'(of[k]), 32'd0);
      end
      rst = 1'b0;
      tick();
      for (int k = 0; k < 3; k++)
         check($sformatf("rst_inrdy%0d", k), 32'(ir[k]), 32'd1);

      // LEN=4 back-to-back, then held result with out_ready low for 5 cycles
      iv[0] = 1'b1;
      pr[0] = 16'd100; ord[0] = 1'b1; tick();
      check("acc_no_early_valid", 32'(ov[0]), 32'd0);
      pr[0] = 16'd200; ord[0] = 1'b0; tick();
      pr[0] = 16'd300; tick();
      pr[0] = 16'd400; tick();
      iv[0] = 1'b0;
      check("b2b_valid", 32'(ov[0]), 32'd1);
      check("b2b_sum", os[0], 32'd1000);
      check("b2b_ovf", 32'(of[0]), 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_sum", os[0], 32'd1000);
         check("hold_inrdy", 32'(ir[0]), 32'd0);
         check("hold_valid", 32'(ov[0]), 32'd1);
      end
      ord[0] = 1'b1;
      tick();
      ord[0] = 1'b0;
      check("release_valid", 32'(ov[0]), 32'd0);
      check("release_inrdy", 32'(ir[0]), 32'd1);

      // ACC_W=16 overflow
      beat(1, 16'hFFFF, 0);
      beat(1, 16'h0002, 1);
`ifdef APPROX_DOT_ACC_SAT_EN
      expect_result(1, 32'hFFFF, 1'b1, 1, "ovf16");
`else
      expect_result(1, 32'h0001, 1'b1, 1, "ovf16");
`endif

      // Reset mid-accumulation discards the partial sum
      beat(0, 16'd5, 0);
      beat(0, 16'd5, 0);
      #3 rst = 1'b1;
      #1;
      check("midrst_inrdy", 32'(ir[0]), 32'd1);
      check("midrst_valid", 32'(ov[0]), 32'd0);
      tick();
      rst = 1'b0;
      beat(0, 16'd1, 2);
      beat(0, 16'd1, 1);
      beat(0, 16'd1, 3);
      beat(0, 16'd1, 0);
      expect_result(0, 32'd4, 1'b0, 0, "midrst");

      // LEN=1 with out_ready held high: one-cycle bubble between results
      ord[2] = 1'b1;
      iv[2]  = 1'b1;
      pr[2]  = 16'd7;
      tick();
      check("len1_a_valid", 32'(ov[2]), 32'd1);
      check("len1_a_sum", os[2], 32'd7);
      check("len1_a_inrdy", 32'(ir[2]), 32'd0);
      pr[2] = 16'd9;
      tick();
      check("len1_bubble_valid", 32'(ov[2]), 32'd0);
      check("len1_bubble_inrdy", 32'(ir[2]), 32'd1);
      tick();
      check("len1_b_valid", 32'(ov[2]), 32'd1);
      check("len1_b_sum", os[2], 32'd9);
      iv[2] = 1'b0;
      tick();
      check("len1_end_valid", 32'(ov[2]), 32'd0);
      ord[2] = 1'b0;

      // Vector table
      for (int i = 0; i < 7; i++) begin
         for (int j = 0; j < tv[i].n; j++)
            beat(tv[i].k, tv[i].b[j], j % 2);
         expect_result(tv[i].k, tv[i].s, tv[i].o, 1, $sformatf("vec%0d", i));
      end

      // Randomized dot products with gaps and stray out_ready during accumulation
      for (int k = 0; k < 3; k++) begin
         for (int t = 0; t < 15; t++) begin
            logic [15:0] v;
            total = 0;
            for (int j = 0; j < LNS[k]; j++) begin
               v = 16'($urandom);
               ord[k] = (j < LNS[k] - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
               total += longint'(v);
               beat(k, v, int'($urandom_range(0, 3)));
            end
            ord[k] = 1'b0;
            model(WID[k], total, es, eo);
            expect_result(k, es, eo, int'($urandom_range(0, 3)), $sformatf("rnd%0d_%0d", k, t));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
